led_pattern_ctrl: RTL and testbench

Parametrised board-level LED/button front end, the successor to the free-running-counter LED blinker. It debounces all buttons and runs a mode state machine advanced by button presses. It drives the LED bank with one of four patterns: counter display, PWM breathing, bouncing scanner, or frozen hold. It sits directly on board pins for bring-up and status indication.

---
 rtl/led_pattern_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_ctrl
// Purpose  : Board-level LED/button front end. Debounces every button, steps
//            a four-mode state machine on button presses and drives the LED
//            bank with a counter, breathing, scanner or frozen pattern. The
//            top LED mirrors debounced button 0.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int NUM_LEDS        = 8,
    parameter int NUM_BTNS        = 7,
    parameter int CTR_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PWM_BITS        = 8,
    parameter int SCAN_DIV_LOG2   = 22
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_BTNS-1:0] i_btn,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [1:0]          o_mode,
    output logic [NUM_BTNS-1:0] o_btn_db
);

    // Pattern LEDs exclude the top LED, which shows button 0.
    localparam int c_P     = NUM_LEDS - 1;
    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_POS_W = (c_P > 1) ? $clog2(c_P) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_POS_W-1:0] c_POS_TOP    = c_POS_W'(c_P - 1);
    localparam logic [c_POS_W-1:0] c_POS_TOP_M1 = c_POS_W'((c_P > 1) ? c_P - 2 : 0);

    localparam logic [1:0] c_MODE_COUNT  = 2'd0;
    localparam logic [1:0] c_MODE_BREATH = 2'd1;
    localparam logic [1:0] c_MODE_SCAN   = 2'd2;
    localparam logic [1:0] c_MODE_HOLD   = 2'd3;

    logic [NUM_BTNS-1:0]  r_sync1;
    logic [NUM_BTNS-1:0]  r_sync2;
    logic [NUM_BTNS-1:0]  r_db;
    logic [NUM_BTNS-1:0]  r_db_prev;
    logic [c_DB_W-1:0]    r_db_cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0]  w_press;

    logic [1:0]           r_mode;
    logic [1:0]           w_mode_next;

    logic [CTR_WIDTH-1:0] r_cnt;
    logic [c_POS_W-1:0]   r_pos;
    logic                 r_dir_up;
    logic                 w_tick;

    logic [PWM_BITS-1:0]  w_ramp;
    logic [PWM_BITS-1:0]  w_duty;
    logic                 w_breath_on;
    logic [c_P-1:0]       w_pat_next;
    logic [NUM_LEDS-1:0]  r_led;

    // Bits not every parameter set consumes; folded here so nothing dangles.
    logic                 w_unused;
    assign w_unused = ^{r_cnt, w_press};

    // Two-flop synchroniser plus stable-time counter per button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int b = 0; b < NUM_BTNS; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int b = 0; b < NUM_BTNS; b++) begin
                if (r_sync2[b] != r_db[b]) begin
                    if (r_db_cnt[b] == c_DB_LAST) begin
                        r_db[b]     <= ~r_db[b];
                        r_db_cnt[b] <= '0;
                    end else begin
                        r_db_cnt[b] <= r_db_cnt[b] + c_DB_W'(1);
                    end
                end else begin
                    r_db_cnt[b] <= '0;
                end
            end
        end
    end

    // One-cycle press pulse on each debounced rising edge.
    assign w_press = r_db & ~r_db_prev;

    // Mode state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= c_MODE_COUNT;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Next mode: button 2 returns to COUNT and overrides button 1's advance.
    always_comb begin
        w_mode_next = r_mode;
        if (w_press[2]) begin
            w_mode_next = c_MODE_COUNT;
        end else if (w_press[1]) begin
            case (r_mode)
                c_MODE_COUNT:  w_mode_next = c_MODE_BREATH;
                c_MODE_BREATH: w_mode_next = c_MODE_SCAN;
                c_MODE_SCAN:   w_mode_next = c_MODE_HOLD;
                default:       w_mode_next = c_MODE_COUNT;
            endcase
        end
    end

    // Mode output decode.
    always_comb begin
        o_mode = r_mode;
    end

    // Free-running counter, frozen while holding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_mode != c_MODE_HOLD) begin
            r_cnt <= r_cnt + CTR_WIDTH'(1);
        end
    end

    assign w_tick = &r_cnt[SCAN_DIV_LOG2-1:0];

    // Scanner position bounces between the ends; kept across mode changes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pos    <= '0;
            r_dir_up <= 1'b1;
        end else if ((r_mode == c_MODE_SCAN) && w_tick && (c_P > 1)) begin
            if (r_dir_up) begin
                if (r_pos == c_POS_TOP) begin
                    r_dir_up <= 1'b0;
                    r_pos    <= c_POS_TOP_M1;
                end else begin
                    r_pos <= r_pos + c_POS_W'(1);
                end
            end else begin
                if (r_pos == '0) begin
                    r_dir_up <= 1'b1;
                    r_pos    <= c_POS_W'(1);
                end else begin
                    r_pos <= r_pos - c_POS_W'(1);
                end
            end
        end
    end

    // Triangle duty from the counter top bits, compared against the low bits.
    assign w_ramp      = r_cnt[CTR_WIDTH-2 -: PWM_BITS];
    assign w_duty      = r_cnt[CTR_WIDTH-1] ? ~w_ramp : w_ramp;
    assign w_breath_on = (r_cnt[PWM_BITS-1:0] < w_duty);

    // Pattern selection for the lower LEDs; HOLD keeps the current value.
    always_comb begin
        w_pat_next = r_led[c_P-1:0];
        case (r_mode)
            c_MODE_COUNT: begin
                for (int i = 0; i < c_P; i++) begin
                    w_pat_next[i] = r_cnt[CTR_WIDTH-1-i];
                end
            end
            c_MODE_BREATH: begin
                w_pat_next = {c_P{w_breath_on}};
            end
            c_MODE_SCAN: begin
                for (int i = 0; i < c_P; i++) begin
                    w_pat_next[i] = (r_pos == c_POS_W'(i));
                end
            end
            default: begin
                w_pat_next = r_led[c_P-1:0];
            end
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led <= '0;
        end else begin
            r_led <= {r_db[0], w_pat_next};
        end
    end

    assign o_led    = r_led;
    assign o_btn_db = r_db;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_ctrl
// Purpose  : Self-checking bench for led_pattern_ctrl with a cycle reference
//            model, directed scenarios and randomized button activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

    localparam int NL = 8;
    localparam int NB = 7;
    localparam int CW = 12;
    localparam int DB = 4;
    localparam int PB = 4;
    localparam int SD = 2;
    localparam int P  = NL - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NL-1:0] led;
    logic [1:0]    mode;
    logic [NB-1:0] db;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .NUM_LEDS        (NL),
        .NUM_BTNS        (NB),
        .CTR_WIDTH       (CW),
        .DEBOUNCE_CYCLES (DB),
        .PWM_BITS        (PB),
        .SCAN_DIV_LOG2   (SD)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_btn    (btn),
        .o_led    (led),
        .o_mode   (mode),
        .o_btn_db (db)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model state
    bit [NB-1:0] m_s1, m_s2, m_db, m_dbp;
    int          m_run [NB];
    int          m_mode, m_cnt, m_pos;
    bit          m_up;
    bit [P-1:0]  m_pat;
    bit [NL-1:0] m_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    function automatic void model_step();
        bit [NB-1:0] press;
        bit [NB-1:0] ndb;
        bit [P-1:0]  npat;
        int          nmode, r, duty;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            m_mode = 0; m_cnt = 0; m_pos = 0; m_up = 1'b1;
            m_pat = '0; m_led = '0;
            return;
        end
        press = m_db & ~m_dbp;
        if (press[2])      nmode = 0;
        else if (press[1]) nmode = (m_mode + 1) % 4;
        else               nmode = m_mode;
        npat = m_pat;
        case (m_mode)
            0: for (int i = 0; i < P; i++) npat[i] = ((m_cnt >> (CW - 1 - i)) & 1) != 0;
            1: begin
                r    = (m_cnt >> (CW - 1 - PB)) % (1 << PB);
                duty = (m_cnt >= (1 << (CW - 1))) ? ((1 << PB) - 1 - r) : r;
                npat = ((m_cnt % (1 << PB)) < duty) ? {P{1'b1}} : '0;
            end
            2: npat = P'(1) << m_pos;
            default: npat = m_pat;
        endcase
        m_led = {m_db[0], npat};
        m_pat = npat;
        if (m_mode == 2 && (m_cnt % (1 << SD)) == (1 << SD) - 1) begin
            if (m_up) begin
                if (m_pos == P - 1) begin m_up = 1'b0; m_pos = P - 2; end
                else m_pos++;
            end else begin
                if (m_pos == 0) begin m_up = 1'b1; m_pos = 1; end
                else m_pos--;
            end
        end
        if (m_mode != 3) m_cnt = (m_cnt + 1) % (1 << CW);
        ndb = m_db;
        for (int b = 0; b < NB; b++) begin
            if (m_s2[b] != m_db[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    ndb[b]   = ~m_db[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_dbp  = m_db;
        m_db   = ndb;
        m_s2   = m_s1;
        m_s1   = btn;
        m_mode = nmode;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("led",    32'(led),  32'(m_led));
        check("mode",   32'(mode), 32'(m_mode));
        check("btn_db", 32'(db),   32'(m_db));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_db(input int b, input logic lvl, input string tag);
        int n = 0;
        while (db[b] !== lvl && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(db[b]), 32'(lvl));
    endtask

    // Clean press: hold until qualified, let the FSM react, then release.
    task automatic press(input int b);
        btn[b] = 1'b1;
        wait_db(b, 1'b1, "press_rise");
        tick();
        btn[b] = 1'b0;
        wait_db(b, 1'b0, "press_fall");
    endtask

    initial begin
        int          first, rise, mrise;
        logic [P-1:0] held;
        logic [P-1:0] last;
        logic [P-1:0] seq [$];
        logic [P-1:0] exp_seq [14];

        // Reset state
        rst = 1'b1;
        ticks(3);
        check("rst_led",  32'(led),  32'h00);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_db",   32'(db),   32'd0);

        // Idle count: first LED0 rise after release
        rst   = 1'b0;
        first = 0;
        for (int n = 1; n <= 2100; n++) begin
            tick();
            if (led[0] && first == 0) first = n;
        end
        check("count_first_led0", 32'(first), 32'd2049);

        // Short glitch must be rejected
        btn[1] = 1'b1;
        ticks(3);
        btn[1] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("glitch_db",   32'(db[1]), 32'd0);
            check("glitch_mode", 32'(mode),  32'd0);
        end

        // Held press: latency of debounce and FSM
        btn[1] = 1'b1;
        rise   = 0;
        mrise  = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (db[1] && rise == 0)     rise  = k;
            if (mode == 2'd1 && mrise == 0) mrise = k;
        end
        check("db_latency",   32'(rise),  32'd6);
        check("mode_latency", 32'(mrise), 32'd7);
        btn[1] = 1'b0;
        ticks(10);

        // Back to COUNT, then cycle through all modes
        press(2);
        check("btn2_to_count", 32'(mode), 32'd0);
        press(1); check("cycle_1", 32'(mode), 32'd1);
        press(1); check("cycle_2", 32'(mode), 32'd2);
        press(1); check("cycle_3", 32'(mode), 32'd3);
        press(1); check("cycle_0", 32'(mode), 32'd0);
        press(1);
        press(1);
        check("pre_both", 32'(mode), 32'd2);
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        wait_db(1, 1'b1, "both_rise");
        tick();
        check("both_btn2_wins", 32'(mode), 32'd0);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        wait_db(1, 1'b0, "both_fall");
        ticks(2);

        // Scanner from a fresh reset (pos=0, moving up)
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        press(1);
        btn[1] = 1'b1;
        wait_db(1, 1'b1, "scan_rise");
        tick();
        check("scan_mode", 32'(mode), 32'd2);
        btn[1] = 1'b0;
        last = 'x;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (led[P-1:0] !== last) begin
                last = led[P-1:0];
                seq.push_back(last);
            end
        end
        exp_seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40,
                    7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01, 7'h02};
        check("scan_len_ok", 32'(seq.size() >= 14), 32'd1);
        for (int i = 0; i < 14; i++) begin
            if (i < seq.size()) check("scan_seq", 32'(seq[i]), 32'(exp_seq[i]));
        end

        // HOLD: pattern frozen while button 0 toggles
        press(1);
        check("hold_mode", 32'(mode), 32'd3);
        held = led[P-1:0];
        for (int n = 0; n < 100; n++) begin
            if (n % 10 == 0) btn[0] = ~btn[0];
            tick();
            check("hold_pattern", 32'(led[P-1:0]), 32'(held));
        end
        btn[0] = 1'b0;
        ticks(10);
        press(1);
        check("hold_exit", 32'(mode), 32'd0);
        ticks(40);

        // Reset while btn1 is held in SCAN
        press(1);
        press(1);
        check("prerst_mode", 32'(mode), 32'd2);
        btn[1] = 1'b1;
        ticks(2);
        rst = 1'b1;
        ticks(2);
        check("inrst_mode", 32'(mode), 32'd0);
        check("inrst_db",   32'(db),   32'd0);
        rst   = 1'b0;
        rise  = 0;
        mrise = 0;
        for (int k = 1; k <= 20 && mrise == 0; k++) begin
            tick();
            if (db[1] && rise == 0)       rise  = k;
            if (mode == 2'd1 && mrise == 0) mrise = k;
        end
        check("post_rst_db",   32'(rise),  32'd6);
        check("post_rst_mode", 32'(mrise), 32'd7);
        btn[1] = 1'b0;
        ticks(10);

        // Randomized button activity against the model
        for (int it = 0; it < 2000; it++) begin
            btn = NB'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            ticks($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
